// File: rtl/pf_pkg.sv
// Shared definitions for the pixel packer: parameter defaults, control states
// and the FIFO entry layout.
package pf_pkg;

    localparam int TILE_W_DEF     = 64;
    localparam int TILE_H_DEF     = 64;
    localparam int N_TILES_DEF    = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } pf_state_e;

    typedef struct packed {
        logic        last;
        logic [3:0]  tile;
        logic [31:0] data;
    } pf_word_t;

    localparam int WORD_W = $bits(pf_word_t);

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pf_word_fifo.sv
// Synchronous word FIFO with a registered head: rdata/valid come straight from
// flops and only change when the head is popped or the FIFO leaves empty.
module pf_word_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             valid_r;
    logic [WIDTH-1:0] rdata_r;

    logic             pop_s;
    logic             push_s;
    logic             full_s;
    logic [AW-1:0]    rd_ptr_nx_s;
    logic [AW:0]      remain_s;
    logic [AW:0]      count_nx_s;
    logic [WIDTH-1:0] head_nx_s;

    // Next-state pointers, occupancy and head; a push into an otherwise empty FIFO bypasses memory.
    always_comb begin
        pop_s       = pop && valid_r;
        full_s      = (count_r == FULL_CNT);
        push_s      = push && (!full_s || pop_s);
        rd_ptr_nx_s = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        remain_s    = pop_s ? (count_r - (AW+1)'(1'b1)) : count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + (AW+1)'(1'b1);
            2'b01:   count_nx_s = count_r - (AW+1)'(1'b1);
            default: count_nx_s = count_r;
        endcase
        head_nx_s = (push_s && (remain_s == ZERO_CNT)) ? wdata : mem_r[rd_ptr_nx_s];
    end

    // Storage array, intentionally not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= ZERO_CNT;
            valid_r  <= 1'b0;
            rdata_r  <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            valid_r  <= (count_nx_s != ZERO_CNT);
            rdata_r  <= head_nx_s;
        end
    end

    assign rdata = rdata_r;
    assign valid = valid_r;
    assign full  = full_s;
    assign empty = (count_r == ZERO_CNT);

endmodule

// File: rtl/pixel_packer.sv
// Packs filtered 8-bit pixels four at a time into 32-bit words tagged with
// tile index and end-of-tile flag, buffered through a small word FIFO.
module pixel_packer
    import pf_pkg::*;
#(
    parameter int TILE_W     = TILE_W_DEF,
    parameter int TILE_H     = TILE_H_DEF,
    parameter int N_TILES    = N_TILES_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rd,
    input  logic [7:0]  cl_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [3:0]  tile_idx,
    output logic        overflow,
    output logic        done
);

    localparam int CW = cnt_w(TILE_W);
    localparam int RW = cnt_w(TILE_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(TILE_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(TILE_H - 1);
    localparam logic [3:0]    TILE_LAST = 4'(N_TILES - 1);

    pf_state_e   state_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [3:0]  tile_r;
    logic [23:0] pack_r;
    logic        push_r;
    pf_word_t    push_word_r;
    logic        overflow_r;
    logic        done_r;

    logic        accept_s;
    logic        col_last_s;
    logic        row_last_s;
    logic        tile_last_s;
    logic        pop_s;
    logic        drop_s;
    logic        final_pop_s;
    logic [WORD_W-1:0] fifo_rdata_s;
    pf_word_t    head_s;
    logic        fifo_valid_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;

    // Acceptance, counter wrap conditions and FIFO handshake decode.
    always_comb begin
        head_s      = fifo_rdata_s;
        accept_s    = en && rd && (state_r == ST_COLLECT);
        col_last_s  = (col_r == COL_LAST);
        row_last_s  = (row_r == ROW_LAST);
        tile_last_s = (tile_r == TILE_LAST);
        pop_s       = fifo_valid_s && out_ready;
        drop_s      = push_r && fifo_full_s && !pop_s;
        final_pop_s = pop_s && head_s.last && (head_s.tile == TILE_LAST);
    end

    // Control FSM together with position counters, lane packing and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            tile_r      <= 4'd0;
            pack_r      <= 24'd0;
            push_r      <= 1'b0;
            push_word_r <= '{last: 1'b0, tile: 4'd0, data: 32'd0};
            overflow_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            push_r <= 1'b0;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (accept_s) begin
                case (col_r[1:0])
                    2'd0: pack_r[7:0]   <= cl_pixel;
                    2'd1: pack_r[15:8]  <= cl_pixel;
                    2'd2: pack_r[23:16] <= cl_pixel;
                    2'd3: begin
                        push_word_r <= '{last: col_last_s && row_last_s,
                                         tile: tile_r,
                                         data: {cl_pixel, pack_r}};
                        push_r      <= 1'b1;
                    end
                    default: pack_r <= pack_r;
                endcase
                if (col_last_s) begin
                    col_r <= {CW{1'b0}};
                    if (row_last_s) begin
                        row_r  <= {RW{1'b0}};
                        tile_r <= tile_last_s ? 4'd0 : (tile_r + 4'd1);
                    end else begin
                        row_r <= row_r + RW'(1'b1);
                    end
                end else begin
                    col_r <= col_r + CW'(1'b1);
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (accept_s && col_last_s && row_last_s && tile_last_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A dropped final word must not leave the block stuck here.
                    if (final_pop_s || (fifo_empty_s && !push_r)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    pf_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_r),
        .wdata (push_word_r),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .valid (fifo_valid_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign out_valid = fifo_valid_s;
    assign out_data  = head_s.data;
    assign out_last  = head_s.last;
    assign tile_idx  = head_s.tile;
    assign overflow  = overflow_r;
    assign done      = done_r;

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 SHALL have parameter TILE_W, default 64, meaning filtered pixels per tile row.
REQ-002 SHALL have parameter TILE_H, default 64, meaning rows per tile.
REQ-003 SHALL have parameter N_TILES, default 16, meaning tiles per frame (one per filter bank).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning output word FIFO entries (power of two).
REQ-005 SHALL use one clock; reset is synchronous and active-low; ports are clk and rst_n.
REQ-006 SHALL have port: clk  input  1  rising-edge clock.
REQ-007 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port: en  input  1  stage enable; rd is ignored while low.
REQ-009 SHALL have port: rd  input  1  filter output pixel valid, one pixel per high cycle.
REQ-010 SHALL have port: cl_pixel  input  8  filtered pixel value.
REQ-011 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-013 SHALL have port: out_data  output  32  four packed pixels, first pixel in bits [7:0].
REQ-014 SHALL have port: out_last  output  1  word holds the last pixel (row TILE_H-1, col TILE_W-1) of a tile.
REQ-015 SHALL have port: tile_idx  output  4  tile index of the current out_data word.
REQ-016 SHALL have port: overflow  output  1  sticky: a word was dropped on a full FIFO.
REQ-017 SHALL have port: done  output  1  sticky: final word of tile N_TILES-1 has been consumed.

Function
REQ-018 SHALL accept a pixel only on a cycle with en=1, rd=1, state COLLECT.
REQ-019 SHALL place accepted pixel k (k = col mod 4) into byte lane k of the packing register.
REQ-020 SHALL push the completed word into the FIFO on the cycle after lane 3 is accepted; out_valid SHALL rise one cycle after that push when the FIFO was empty (2-cycle latency from 4th pixel).
REQ-021 SHALL maintain col (0..TILE_W-1), row (0..TILE_H-1), tile (0..N_TILES-1) counters advancing per accepted pixel, col wrapping into row, row wrapping into tile.
REQ-022 SHALL store out_last and tile index alongside each word in the FIFO.
REQ-023 SHALL hold out_data, out_last, tile_idx stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on a push to a full FIFO without a simultaneous pop, drop the word, set overflow, and still advance counters.
REQ-025 SHALL allow simultaneous push and pop when full without overflow.
REQ-026 SHALL implement states IDLE, COLLECT, DRAIN, DONE: IDLE->COLLECT when en=1; COLLECT->DRAIN after the last pixel of tile N_TILES-1 is accepted; DRAIN->DONE when the last word is popped; DONE holds until reset.
REQ-027 SHALL ignore rd in IDLE, DRAIN and DONE; en=0 in COLLECT SHALL freeze counters and packing register.

Reset
REQ-028 SHALL, on rst_n=0 at a clock edge, clear counters, packing register, FIFO pointers, and drive out_valid=0, out_data=0, out_last=0, tile_idx=0, overflow=0, done=0, state IDLE.
REQ-029 SHALL discard any partial word and FIFO content on reset mid-operation.

Structure
REQ-030 SHALL take TILE_W, TILE_H, N_TILES, FIFO_DEPTH defaults and the state enum from shared package pf_pkg.
REQ-031 SHALL instantiate one sub-module pf_word_fifo (synchronous FIFO, 32+1+4 bits wide, full/empty flags).

Verification
REQ-032 SHALL cover: pixels 0x01,0x02,0x03,0x04 on consecutive cycles, out_ready=1 -> out_data=0x04030201 two cycles after 4th pixel, tile_idx=0, out_last=0.
REQ-033 SHALL cover: full tile of 4096 pixels -> 1024 words, out_last=1 only on word 1023, next word tile_idx=1.
REQ-034 SHALL cover: out_ready=0 for 40 consecutive pixels (10 words) with depth 8 -> overflow=1 after the 9th word, 8 words retained intact.
REQ-035 SHALL cover: en toggled low mid-word with rd=1 -> those pixels ignored, resumed word packs correctly.
REQ-036 SHALL cover: all 16 tiles streamed, out_ready=1 -> done=1 one cycle after final pop; further rd causes no out_valid.
REQ-037 SHALL cover: rst_n=0 after 2 pixels of a word -> all outputs 0, next 4 pixels form word at tile 0, row 0, col 0.
